// File: rtl/pdm_pkg.sv
// Shared constants, LFSR helper and sample-pair type for the stereo PDM transmitter.
// The LFSR items are only used when PDM_TX_DITHER_EN is defined.
package pdm_pkg;

    localparam int PDM_W       = 16;
    localparam int PDM_CLK_DIV = 8;
    localparam int PDM_DECIM   = 64;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [PDM_W-1:0] left;
        logic [PDM_W-1:0] right;
    } pcm_pair_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pdm_sd_mod.sv
// First-order sigma-delta modulator: carry out of (acc + offset-binary sample) is the PDM bit.
// With PDM_TX_DITHER_EN defined, an LFSR bit replaces the sample LSB before the add.
module pdm_sd_mod
    import pdm_pkg::*;
#(
    parameter int W = PDM_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_step,
    input  logic [W-1:0] i_sample,
    output logic         o_bit
);

    logic [W-1:0] r_acc;
    logic [W-1:0] w_u;
    logic [W:0]   w_sum;

`ifdef PDM_TX_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_u = {~i_sample[W-1], i_sample[W-2:1], r_lfsr[0]};
`else
    assign w_u = {~i_sample[W-1], i_sample[W-2:0]};
`endif

    assign w_sum = {1'b0, r_acc} + {1'b0, w_u};
    assign o_bit = w_sum[W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/pdm_mic_tx.sv
// Stereo PDM microphone emulator: PCM pairs in, PDM clock plus shared L/R data line out.
// Optional LFSR dither in the modulators is enabled by defining PDM_TX_DITHER_EN.
module pdm_mic_tx
    import pdm_pkg::*;
#(
    parameter int W       = PDM_W,
    parameter int CLK_DIV = PDM_CLK_DIV,
    parameter int DECIM   = PDM_DECIM
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_left,
    input  logic [W-1:0] s_right,
    output logic         pdm_clk,
    output logic         pdm_data,
    output logic         frame_strobe,
    output logic         underrun
);

    localparam int PH_W = $clog2(CLK_DIV);
    localparam int BC_W = $clog2(DECIM);

    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF_M1 = PH_W'(CLK_DIV / 2 - 1);
    localparam logic [PH_W-1:0] PH_Q1_M1   = PH_W'(CLK_DIV / 4 - 1);
    localparam logic [PH_W-1:0] PH_Q3_M1   = PH_W'(3 * CLK_DIV / 4 - 1);
    localparam logic [BC_W-1:0] BC_LAST    = BC_W'(DECIM - 1);

    logic [PH_W-1:0] r_ph;
    logic [BC_W-1:0] r_bc;
    logic            r_clk_lvl;
    logic            r_data;
    logic            r_strobe;
    logic            r_underrun;
    logic            r_hold_valid;
    logic [W-1:0]    r_hold [2];
    logic [W-1:0]    r_act  [2];

    logic       w_wrap;
    logic       w_boundary;
    logic       w_xfer;
    logic [1:0] w_step;
    logic [1:0] w_bit;

    assign w_wrap     = en && (r_ph == PH_LAST);
    assign w_boundary = w_wrap && (r_bc == BC_LAST);
    assign w_xfer     = s_valid && !r_hold_valid;

    // Left bit launched at mid-low, right bit at mid-high of the PDM clock
    assign w_step[0] = en && (r_ph == PH_Q3_M1);
    assign w_step[1] = en && (r_ph == PH_Q1_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph         <= '0;
            r_bc         <= '0;
            r_clk_lvl    <= 1'b0;
            r_data       <= 1'b0;
            r_strobe     <= 1'b0;
            r_underrun   <= 1'b0;
            r_hold_valid <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_hold[i] <= '0;
                r_act[i]  <= '0;
            end
        end else begin
            if (en) begin
                r_ph <= w_wrap ? '0 : r_ph + 1'b1;
            end
            if (w_wrap) begin
                r_bc <= (r_bc == BC_LAST) ? '0 : r_bc + 1'b1;
            end

            // Clock level only rises on a wrap, so the first high phase follows a full period
            if (w_wrap) begin
                r_clk_lvl <= 1'b1;
            end else if (en && (r_ph == PH_HALF_M1)) begin
                r_clk_lvl <= 1'b0;
            end

            if (w_step[0]) begin
                r_data <= w_bit[0];
            end else if (w_step[1]) begin
                r_data <= w_bit[1];
            end

            r_strobe <= w_boundary;

            // Boundary sees hold_valid before any same-cycle transfer
            if (w_boundary) begin
                if (r_hold_valid) begin
                    r_act[0] <= r_hold[0];
                    r_act[1] <= r_hold[1];
                end else begin
                    r_underrun <= 1'b1;
                end
            end

            if (w_xfer) begin
                r_hold[0]    <= s_left;
                r_hold[1]    <= s_right;
                r_hold_valid <= 1'b1;
            end else if (w_boundary && r_hold_valid) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            pdm_sd_mod #(
                .W(W)
            ) u_mod (
                .clk      (clk),
                .rst      (rst),
                .i_step   (w_step[gi]),
                .i_sample (r_act[gi]),
                .o_bit    (w_bit[gi])
            );
        end
    endgenerate

    assign s_ready      = !r_hold_valid;
    assign pdm_clk      = r_clk_lvl & en;
    assign pdm_data     = r_data & en;
    assign frame_strobe = r_strobe;
    assign underrun     = r_underrun;

endmodule
